rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
//
// PURPOSE
//  Shares the single register-file write port between two writeback sources:
//  the ALU path (src "alu") and the load/memory path (src "mem").
//  Arbitrates one write per cycle with valid/ready handshakes.
//  Registers the winner onto reg_write/wr_rd/wr_data, which drive the register file.
//  Fixed priority goes to mem, with an anti-starvation timer that guarantees alu progress.
//
// PARAMETERS
//  MAX_WAIT  4  cycles alu may wait while valid before it is force-granted over mem (legal range 1..255)
//  (widths come from PARAMS_pkg: INSTR_REG_SIZE = rd index width, WD_SIZE = data width)
//
// PORTS
//  clk        in   1               clock; all state updates on posedge
//  reset      in   1               synchronous reset, active-high
//  alu_valid  in   1               alu writeback request
//  alu_ready  out  1               alu request granted this cycle
//  alu_rd     in   INSTR_REG_SIZE  alu destination register
//  alu_data   in   WD_SIZE         alu result
//  mem_valid  in   1               mem writeback request
//  mem_ready  out  1               mem request granted this cycle
//  mem_rd     in   INSTR_REG_SIZE  mem destination register
//  mem_data   in   WD_SIZE         load result
//  reg_write  out  1               register-file write enable (registered)
//  wr_rd      out  INSTR_REG_SIZE  register-file write index (registered)
//  wr_data    out  WD_SIZE         register-file write data (registered)
//  alu_forced out  1               alu grant this cycle came from the starvation timer
//
// BEHAVIOUR
//  - Reset (reset=1 at posedge):
//    - reg_write=0, wr_rd=0, wr_data=0, wait_cnt=0.
//    - alu_ready=mem_ready=alu_forced=0 combinationally while reset=1.
//  - wait_cnt: width $clog2(MAX_WAIT+1), saturating at MAX_WAIT.
//  - force = alu_valid && (wait_cnt == MAX_WAIT).
//  - Grant (combinational, single-cycle):
//    - mem_ready = mem_valid && !force
//    - alu_ready = alu_valid && (!mem_valid || force)
//    - alu_forced = alu_ready && force && mem_valid
//    - At most one ready is high in any cycle.
//  - Transfer = valid && ready at posedge.
//    - Sources hold valid, rd and data stable until ready; the arbiter does not check this.
//  - wait_cnt update, next cycle:
//    - 0 if !alu_valid or alu transfers.
//    - +1 (saturating) if alu_valid and not granted.
//  - Output stage, 1-cycle latency (transfer at edge N -> write presented in cycle N+1):
//    - transfer with rd != 0: reg_write<=1, wr_rd<=rd, wr_data<=data.
//    - transfer with rd == 0: the request is consumed, reg_write<=0, wr_rd/wr_data hold.
//    - no transfer: reg_write<=0, wr_rd/wr_data hold.
//  - reg_write is a one-cycle pulse per accepted write. The output never back-pressures.
//  - Both sources valid with the same rd: the grant follows the policy above.
//    - The later-granted write lands last and overwrites.
//    - Ordering between sources is the issue logic's responsibility.
//  - Reset mid-operation: a grant in the reset cycle is discarded, and wait_cnt clears.
//    - reg_write is 0 in the cycle after reset.
//    - Sources must re-present their requests.
//
// CONFIGURATION
//  Macro RF_WB_FWD_EN enables bypass outputs:
//  - fwd_valid (1), fwd_rd (INSTR_REG_SIZE), fwd_data (WD_SIZE).
//  - These equal reg_write/wr_rd/wr_data of the output stage, so decode can bypass the
//    value being written this cycle.
//  - fwd_valid=0 on reset and when rd==0.
//  Without RF_WB_FWD_EN these ports are absent, with no extra logic.
//
// TESTING
//  1. Reset held 2 cycles with both valid=1 -> both readys=0, reg_write=0; after release, mem wins first.
//  2. alu only, rd=5, data=0xDEADBEEF at edge N -> alu_ready=1 in cycle N;
//     reg_write=1, wr_rd=5, wr_data=0xDEADBEEF in cycle N+1 only.
//  3. mem and alu valid continuously, MAX_WAIT=4 -> mem granted 4 cycles, then alu granted with
//     alu_forced=1; wait_cnt=0 afterwards; the pattern repeats mem x4, alu x1.
//  4. alu rd=0, data=0x1234 -> alu_ready=1, request consumed; reg_write stays 0; wr_rd/wr_data unchanged.
//  5. reset asserted while mem granted (mem rd=7) -> reg_write=0 next cycle; x7 is not written.
//  6. RF_WB_FWD_EN defined, mem rd=3, data=0x55 -> fwd_valid=1, fwd_rd=3, fwd_data=0x55 in the same
//     cycle as reg_write.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between two writeback sources.
//   - "alu" is the ALU result path.
//   - "mem" is the load/memory path.
//   One write is granted per cycle using valid/ready handshakes.
//   mem has fixed priority. A starvation timer force-grants alu after it has
//   waited MAX_WAIT cycles while valid, so alu always makes progress.
//   The winner is registered onto reg_write/wr_rd/wr_data with one cycle of
//   latency. A write to rd==0 is accepted but never reaches the register file.
//
// Parameters:
//   MAX_WAIT        cycles alu may wait while valid before it is force-granted
//                   (legal range 1..255)
//   INSTR_REG_SIZE  destination register index width
//   WD_SIZE         data width
//
// Ports:
//   clk         clock; all state updates on posedge
//   reset       synchronous reset, active-high
//   alu_valid   alu writeback request
//   alu_ready   alu request granted this cycle (combinational)
//   alu_rd      alu destination register
//   alu_data    alu result
//   mem_valid   mem writeback request
//   mem_ready   mem request granted this cycle (combinational)
//   mem_rd      mem destination register
//   mem_data    load result
//   reg_write   register-file write enable (registered, one-cycle pulse)
//   wr_rd       register-file write index (registered)
//   wr_data     register-file write data (registered)
//   alu_forced  the alu grant this cycle came from the starvation timer
//
// Optional feature (macro RF_WB_FWD_EN):
//   Adds the bypass outputs fwd_valid/fwd_rd/fwd_data. They mirror the output
//   stage, so decode can bypass the value being written this cycle.
// ----------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int MAX_WAIT       = 4,
    parameter int INSTR_REG_SIZE = 5,
    parameter int WD_SIZE        = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [INSTR_REG_SIZE-1:0] alu_rd,
    input  logic [WD_SIZE-1:0]        alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [INSTR_REG_SIZE-1:0] mem_rd,
    input  logic [WD_SIZE-1:0]        mem_data,
    output logic                      reg_write,
    output logic [INSTR_REG_SIZE-1:0] wr_rd,
    output logic [WD_SIZE-1:0]        wr_data,
`ifdef RF_WB_FWD_EN
    output logic                      fwd_valid,
    output logic [INSTR_REG_SIZE-1:0] fwd_rd,
    output logic [WD_SIZE-1:0]        fwd_data,
`endif
    output logic                      alu_forced
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0]             wait_cnt_q, wait_cnt_d;
    logic                      reg_write_q, reg_write_d;
    logic [INSTR_REG_SIZE-1:0] wr_rd_q, wr_rd_d;
    logic [WD_SIZE-1:0]        wr_data_q, wr_data_d;

    logic force_grant;
    logic alu_grant;
    logic mem_grant;

    // The starvation timer overrides mem priority once alu has waited MAX_WAIT cycles.
    assign force_grant = alu_valid && (wait_cnt_q == WAIT_MAX);

    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        // Grants are suppressed during reset, so a request in the reset cycle is dropped.
        if (!reset) begin
            mem_grant = mem_valid && !force_grant;
            alu_grant = alu_valid && (!mem_valid || force_grant);
        end
    end

    assign alu_ready  = alu_grant;
    assign mem_ready  = mem_grant;
    assign alu_forced = alu_grant && force_grant && mem_valid;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!alu_valid || alu_grant) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Output stage. A consumed rd==0 request produces no write, and the index
    // and data hold their previous values.
    always_comb begin
        reg_write_d = 1'b0;
        wr_rd_d     = wr_rd_q;
        wr_data_d   = wr_data_q;
        if (alu_grant) begin
            if (alu_rd != '0) begin
                reg_write_d = 1'b1;
                wr_rd_d     = alu_rd;
                wr_data_d   = alu_data;
            end
        end else if (mem_grant) begin
            if (mem_rd != '0) begin
                reg_write_d = 1'b1;
                wr_rd_d     = mem_rd;
                wr_data_d   = mem_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q  <= '0;
            reg_write_q <= 1'b0;
            wr_rd_q     <= '0;
            wr_data_q   <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            reg_write_q <= reg_write_d;
            wr_rd_q     <= wr_rd_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign reg_write = reg_write_q;
    assign wr_rd     = wr_rd_q;
    assign wr_data   = wr_data_q;

`ifdef RF_WB_FWD_EN
    // reg_write is already low on reset and for rd==0, so the bypass is a direct copy.
    assign fwd_valid = reg_write_q;
    assign fwd_rd    = wr_rd_q;
    assign fwd_data  = wr_data_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int IW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid, mem_valid;
    logic          alu_ready, mem_ready, alu_forced;
    logic [IW-1:0] alu_rd, mem_rd, wr_rd;
    logic [DW-1:0] alu_data, mem_data, wr_data;
    logic          reg_write;
`ifdef RF_WB_FWD_EN
    logic          fwd_valid;
    logic [IW-1:0] fwd_rd;
    logic [DW-1:0] fwd_data;
`endif

    rf_wb_arbiter #(.MAX_WAIT(4), .INSTR_REG_SIZE(IW), .WD_SIZE(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .reg_write  (reg_write),
        .wr_rd      (wr_rd),
        .wr_data    (wr_data),
`ifdef RF_WB_FWD_EN
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
`endif
        .alu_forced (alu_forced)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [IW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           sb[$];
    int            cyc    = 0;
    int            checks = 0;
    int            passes = 0;
    logic [IW-1:0] exp_rd   = '0;
    logic [DW-1:0] exp_data = '0;

    task automatic chk(input logic [DW-1:0] obs, input logic [DW-1:0] exp, input string tag);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // One cycle: inputs are already driven. Check the grants against the directed
    // expectation, then check the output stage against the scoreboard. Finally,
    // push what the coming edge should write, and advance.
    task automatic step(input logic ea, input logic em, input logic ef, input string tag);
        wr_t e;
        #3;
        chk(32'(alu_ready),  32'(ea), {tag, "_alu_ready"});
        chk(32'(mem_ready),  32'(em), {tag, "_mem_ready"});
        chk(32'(alu_forced), 32'(ef), {tag, "_alu_forced"});
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            exp_rd   = e.rd;
            exp_data = e.data;
            chk(32'(reg_write), 32'd1, {tag, "_reg_write"});
        end else begin
            chk(32'(reg_write), 32'd0, {tag, "_reg_write"});
        end
        chk(32'(wr_rd), 32'(exp_rd), {tag, "_wr_rd"});
        chk(wr_data, exp_data, {tag, "_wr_data"});
`ifdef RF_WB_FWD_EN
        chk(32'(fwd_valid), 32'(reg_write), {tag, "_fwd_valid"});
        chk(32'(fwd_rd), 32'(exp_rd), {tag, "_fwd_rd"});
        chk(fwd_data, exp_data, {tag, "_fwd_data"});
`endif
        $display("cyc=%0d %s alu_rdy=%b mem_rdy=%b forced=%b reg_write=%b wr_rd=%0d wr_data=%h",
                 cyc, tag, alu_ready, mem_ready, alu_forced, reg_write, wr_rd, wr_data);
        if (reset) begin
            exp_rd   = '0;
            exp_data = '0;
        end else begin
            if (ea && alu_valid && alu_rd != '0) sb.push_back('{cyc + 1, alu_rd, alu_data});
            if (em && mem_valid && mem_rd != '0) sb.push_back('{cyc + 1, mem_rd, mem_data});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset held two cycles with both sources valid
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_0011;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h0000_0022;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0, "rst0");
        step(1'b0, 1'b0, 1'b0, "rst1");
        reset = 1'b0;
        step(1'b0, 1'b1, 1'b0, "post_rst_mem_first");
        mem_valid = 1'b0;
        step(1'b1, 1'b0, 1'b0, "post_rst_alu");

        // 2: alu only, single write, one-cycle pulse
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
        step(1'b1, 1'b0, 1'b0, "alu_only");
        alu_valid = 1'b0;
        step(1'b0, 1'b0, 1'b0, "alu_only_wr");
        step(1'b0, 1'b0, 1'b0, "alu_only_idle");

        // 3: both valid continuously; pattern mem x4 then forced alu, twice
        alu_valid = 1'b1; mem_valid = 1'b1; alu_rd = 5'd9; mem_rd = 5'd10;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                mem_data = 32'hB000_0000 + 32'(r * 16 + k);
                step(1'b0, 1'b1, 1'b0, "starve_mem");
            end
            alu_data = 32'hA000_0000 + 32'(r);
            step(1'b1, 1'b0, 1'b1, "starve_alu_forced");
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        step(1'b0, 1'b0, 1'b0, "starve_drain");

        // same rd from both sources: mem lands first, alu overwrites after
        alu_valid = 1'b1; mem_valid = 1'b1; alu_rd = 5'd4; mem_rd = 5'd4;
        alu_data = 32'h0000_0A4A; mem_data = 32'h0000_0B4B;
        step(1'b0, 1'b1, 1'b0, "same_rd_mem");
        mem_valid = 1'b0;
        step(1'b1, 1'b0, 1'b0, "same_rd_alu");
        alu_valid = 1'b0;
        step(1'b0, 1'b0, 1'b0, "same_rd_last");

        // 4: alu rd=0 is consumed without a write; index/data hold
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
        step(1'b1, 1'b0, 1'b0, "rd0_grant");
        alu_valid = 1'b0;
        step(1'b0, 1'b0, 1'b0, "rd0_nowrite");

        // 6: mem-only write (bypass outputs are checked in every step when enabled)
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h0000_0055;
        step(1'b0, 1'b1, 1'b0, "mem_rd3");
        mem_valid = 1'b0;
        step(1'b0, 1'b0, 1'b0, "mem_rd3_wr");

        // 5: reset while mem is requesting rd=7; nothing is written
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h0000_0077;
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, "rst_mid");
        reset = 1'b0; mem_valid = 1'b0;
        step(1'b0, 1'b0, 1'b0, "rst_mid_after");
        step(1'b0, 1'b0, 1'b0, "rst_mid_idle");

        chk(32'(sb.size()), 32'd0, "scoreboard_empty");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
